vote_key_capture: RTL and testbench
===================================

Name: vote_key_capture

Overview:
- Parametrised, registered successor to the ballot-unit one-hot key encoder.
- Synchronises N candidate key lines and debounces a single-key press.
- Rejects multi-key presses and encodes the accepted key to a binary candidate index.
- Delivers exactly one vote per ballot enable to the tally/control unit over a valid/ready handshake.

Parameters:
- N_CAND, 16, number of candidate keys (≥2).
- IDX_W, $clog2(N_CAND), width of the encoded candidate index.
- STABLE_CYCLES, 4, consecutive matching synchronised samples required after first detection before the vote is accepted (≥1).
- CNT_W, $clog2(STABLE_CYCLES+1), debounce counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ballot_en  in  1  level from control unit; high = ballot open for one vote.
- key_in  in  N_CAND  raw candidate keys, bit i = candidate i, asynchronous.
- vote_ready  in  1  tally unit accepts vote.
- vote_valid  out  1  captured vote available.
- vote_idx  out  IDX_W  encoded candidate index, valid while vote_valid.
- multi_err  out  1  one-cycle pulse on multi-key detection.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; synchroniser flops 0; vote_valid=0, vote_idx=0, multi_err=0, busy=0; counter and latched pattern 0.
- key_in passes a 2-flop synchroniser per bit; key_s denotes its output. All decisions use key_s.
- IDLE: go to ARMED when ballot_en=1 and key_s=0. Keys held at ballot open are not accepted until released.
- ARMED:
  - ballot_en=0 → IDLE.
  - key_s exactly one-hot → SETTLE; latch pattern; cnt=1.
  - popcount(key_s)>1 → pulse multi_err; go to RELEASE.
  - key_s=0 → stay.
- SETTLE:
  - ballot_en=0 → IDLE (abort, no vote).
  - key_s ≠ latched pattern:
    - multi-hot → multi_err pulse, RELEASE.
    - zero or a different one-hot → ARMED (no error).
  - Match and cnt<STABLE_CYCLES → cnt+1.
  - Match and cnt=STABLE_CYCLES → HOLD; vote_valid=1; vote_idx=encode(pattern).
- Latency: key_in one-hot and stable from edge t → vote_valid high after edge t+2+STABLE_CYCLES.
- HOLD:
  - vote_valid=1 and vote_idx stable until transfer (vote_valid & vote_ready sampled at an edge).
  - On transfer: vote_valid=0 next cycle; go to DONE.
  - ballot_en drop and key changes are ignored; the vote is committed.
- DONE: go to IDLE when ballot_en=0 and key_s=0. Exactly one vote per ballot_en high period.
- RELEASE: when key_s=0, go to ARMED if ballot_en=1, else IDLE. No further multi_err pulses until RELEASE is left.
- multi_err is registered, exactly 1 cycle per detection event.
- Encoding: vote_idx = binary index of the single set bit, LSB = candidate 0.
- Reset mid-HOLD drops vote_valid immediately. The vote is lost; that is the required behaviour.

Optional Feature:
- Macro: MULTI_ERR_CNT_EN.
- When defined:
  - Adds output multi_err_cnt [7:0].
  - Increments on each multi_err pulse and saturates at 255.
  - Cleared only by rst_n.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package vote_key_pkg holds:
  - state enum {IDLE, ARMED, SETTLE, HOLD, DONE, RELEASE};
  - MULTI_ERR_CNT_W=8;
  - function onehot_to_idx.
- Sub-module onehot_check (combinational) computes is_zero, is_onehot and is_multi, plus the encoded index from key_s, parametrised by N_CAND.
- Synchroniser and FSM stay in the top.

Test Plan:
- N_CAND=16, STABLE_CYCLES=4. ballot_en=1, key_in=16'h0020 from edge t, vote_ready=1 → vote_valid high after edge t+6, vote_idx=5, single transfer, then DONE.
- key_in=16'h0008 for 3 cycles, then 0, then 16'h0400 held → no vote for idx 3; vote_idx=10, multi_err never pulses.
- key_in=16'h0081 in ARMED → one multi_err pulse, no vote_valid. Release, then 16'h0001 held → vote_idx=0.
- vote_ready=0 for 10 cycles in HOLD while key_in changes and ballot_en drops → vote_valid and vote_idx=7 held; transfer on vote_ready=1; no second vote until ballot_en re-rises with keys released.
- ballot_en rises with key_in=16'h8000 already held → stays IDLE. Release, press again → vote_idx=15.
- rst_n low mid-SETTLE and mid-HOLD → all outputs 0 asynchronously; with MULTI_ERR_CNT_EN, multi_err_cnt=0, and after 3 multi-key events the count reads 3.

Source files
------------

// File: rtl/vote_key_pkg.sv
// ---------------------------------------------------------------------------
// vote_key_pkg
// Shared types and helpers for the ballot-unit key capture block.
//   vote_state_t    : capture FSM states
//   MULTI_ERR_CNT_W : width of the optional multi-key event counter
//   MAX_CAND        : widest key vector onehot_to_idx can encode
//   onehot_to_idx() : binary index of the single set bit (LSB = index 0)
// ---------------------------------------------------------------------------
package vote_key_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        SETTLE  = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4,
        RELEASE = 3'd5
    } vote_state_t;

    localparam int MULTI_ERR_CNT_W = 8;
    localparam int MAX_CAND        = 256;

    // OR of the indices of all set bits. For a one-hot input this is the
    // index of the set bit; callers only rely on it for one-hot vectors.
    // Unused upper bits are constant zero and fold away in synthesis.
    function automatic int unsigned onehot_to_idx(input logic [MAX_CAND-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_CAND; i++) begin
            if (vec[i]) begin
                idx = idx | int'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_check.sv
// ---------------------------------------------------------------------------
// onehot_check
// Combinational classifier for the synchronised key vector.
//   i_key       [N_CAND] : synchronised key lines
//   o_is_zero            : no key pressed
//   o_is_onehot          : exactly one key pressed
//   o_is_multi           : two or more keys pressed
//   o_idx       [IDX_W]  : binary index of the pressed key (meaningful only
//                          when o_is_onehot is high)
// ---------------------------------------------------------------------------
module onehot_check
    import vote_key_pkg::*;
#(
    parameter int N_CAND = 16,
    parameter int IDX_W  = $clog2(N_CAND)
) (
    input  logic [N_CAND-1:0] i_key,
    output logic              o_is_zero,
    output logic              o_is_onehot,
    output logic              o_is_multi,
    output logic [IDX_W-1:0]  o_idx
);

    logic [N_CAND-1:0]   w_low_cleared;
    logic [MAX_CAND-1:0] w_vec;

    // Clearing the lowest set bit leaves zero exactly when at most one bit
    // was set, which avoids a full popcount adder tree.
    assign w_low_cleared = i_key & (i_key - N_CAND'(1));

    assign o_is_zero   = (i_key == '0);
    assign o_is_onehot = !o_is_zero && (w_low_cleared == '0);
    assign o_is_multi  = !o_is_zero && (w_low_cleared != '0);

    always_comb begin
        w_vec                = '0;
        w_vec[N_CAND-1:0]    = i_key;
    end

    assign o_idx = IDX_W'(onehot_to_idx(w_vec));

endmodule

// File: rtl/vote_key_capture.sv
// ---------------------------------------------------------------------------
// vote_key_capture
// Synchronises and debounces the candidate keys of a ballot unit, rejects
// multi-key presses and hands exactly one encoded vote per ballot opening to
// the tally unit over a valid/ready handshake.
//
// Ports
//   clk            : system clock
//   rst_n          : asynchronous active-low reset (synchronous release
//                    expected from the reset controller)
//   ballot_en      : ballot open level from the control unit
//   key_in [N_CAND]: raw asynchronous key lines, bit i = candidate i
//   vote_ready     : tally unit accepts the vote
//   vote_valid     : captured vote available
//   vote_idx [IDX_W]: encoded candidate index, held while vote_valid
//   multi_err      : one-cycle pulse per multi-key detection
//   busy           : high whenever the FSM is not IDLE
//   multi_err_cnt [8]: saturating multi-key event count (only when the
//                    MULTI_ERR_CNT_EN macro is defined)
// ---------------------------------------------------------------------------
module vote_key_capture
    import vote_key_pkg::*;
#(
    parameter int N_CAND        = 16,
    parameter int IDX_W         = $clog2(N_CAND),
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ballot_en,
    input  logic [N_CAND-1:0]          key_in,
    input  logic                       vote_ready,
    output logic                       vote_valid,
    output logic [IDX_W-1:0]           vote_idx,
    output logic                       multi_err,
`ifdef MULTI_ERR_CNT_EN
    output logic [MULTI_ERR_CNT_W-1:0] multi_err_cnt,
`endif
    output logic                       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // -----------------------------------------------------------------------
    // Two-flop synchroniser per key line
    // -----------------------------------------------------------------------
    logic [N_CAND-1:0] w_key_s;

    genvar gi;
    generate
        for (gi = 0; gi < N_CAND; gi++) begin : g_sync
            logic r_meta;
            logic r_stable;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_meta   <= 1'b0;
                    r_stable <= 1'b0;
                end else begin
                    r_meta   <= key_in[gi];
                    r_stable <= r_meta;
                end
            end

            assign w_key_s[gi] = r_stable;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Key classification
    // -----------------------------------------------------------------------
    logic             w_is_zero;
    logic             w_is_onehot;
    logic             w_is_multi;
    logic [IDX_W-1:0] w_idx;

    onehot_check #(
        .N_CAND (N_CAND),
        .IDX_W  (IDX_W)
    ) u_onehot_check (
        .i_key       (w_key_s),
        .o_is_zero   (w_is_zero),
        .o_is_onehot (w_is_onehot),
        .o_is_multi  (w_is_multi),
        .o_idx       (w_idx)
    );

    // -----------------------------------------------------------------------
    // Capture FSM with registered outputs
    // -----------------------------------------------------------------------
    vote_state_t       r_state;
    logic [N_CAND-1:0] r_pattern;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_vote_valid;
    logic [IDX_W-1:0]  r_vote_idx;
    logic              r_multi_err;
    logic              r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pattern    <= '0;
            r_cnt        <= '0;
            r_vote_valid <= 1'b0;
            r_vote_idx   <= '0;
            r_multi_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_multi_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    // A key already held when the ballot opens must be
                    // released before anything can be accepted.
                    if (ballot_en && w_is_zero) begin
                        r_state <= ARMED;
                        r_busy  <= 1'b1;
                    end
                end

                ARMED: begin
                    if (!ballot_en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_is_onehot) begin
                        r_state   <= SETTLE;
                        r_pattern <= w_key_s;
                        r_cnt     <= CNT_W'(1);
                    end else if (w_is_multi) begin
                        r_multi_err <= 1'b1;
                        r_state     <= RELEASE;
                    end
                end

                SETTLE: begin
                    if (!ballot_en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_key_s != r_pattern) begin
                        if (w_is_multi) begin
                            r_multi_err <= 1'b1;
                            r_state     <= RELEASE;
                        end else begin
                            // Bounce or a switch to another single key:
                            // start over quietly.
                            r_state <= ARMED;
                        end
                    end else if (r_cnt < CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state      <= HOLD;
                        r_vote_valid <= 1'b1;
                        r_vote_idx   <= w_idx;
                    end
                end

                HOLD: begin
                    // Vote is committed: ballot_en and keys are ignored here.
                    if (r_vote_valid && vote_ready) begin
                        r_vote_valid <= 1'b0;
                        r_state      <= DONE;
                    end
                end

                DONE: begin
                    if (!ballot_en && w_is_zero) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                RELEASE: begin
                    if (w_is_zero) begin
                        if (ballot_en) begin
                            r_state <= ARMED;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_vote_valid <= 1'b0;
                end
            endcase
        end
    end

    assign vote_valid = r_vote_valid;
    assign vote_idx   = r_vote_idx;
    assign multi_err  = r_multi_err;
    assign busy       = r_busy;

`ifdef MULTI_ERR_CNT_EN
    // -----------------------------------------------------------------------
    // Saturating multi-key event counter, cleared only by reset
    // -----------------------------------------------------------------------
    logic [MULTI_ERR_CNT_W-1:0] r_multi_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_multi_err_cnt <= '0;
        end else if (r_multi_err && (r_multi_err_cnt != '1)) begin
            r_multi_err_cnt <= r_multi_err_cnt + MULTI_ERR_CNT_W'(1);
        end
    end

    assign multi_err_cnt = r_multi_err_cnt;
`endif

endmodule

// File: tb/tb_vote_key_capture.sv
// ---------------------------------------------------------------------------
// tb_vote_key_capture
// Self-checking bench for vote_key_capture (N_CAND=16, STABLE_CYCLES=4).
// Expected vote indices are queued when a key press is driven and compared
// when the DUT transfers a vote. Define MULTI_ERR_CNT_EN to also check the
// optional multi-key counter.
// ---------------------------------------------------------------------------
module tb_vote_key_capture;

    localparam int N_CAND        = 16;
    localparam int IDX_W         = 4;
    localparam int STABLE_CYCLES = 4;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              ballot_en  = 1'b0;
    logic [N_CAND-1:0] key_in     = '0;
    logic              vote_ready = 1'b1;
    logic              vote_valid;
    logic [IDX_W-1:0]  vote_idx;
    logic              multi_err;
    logic              busy;
`ifdef MULTI_ERR_CNT_EN
    logic [7:0]        multi_err_cnt;
`endif

    vote_key_capture #(
        .N_CAND        (N_CAND),
        .IDX_W         (IDX_W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ballot_en     (ballot_en),
        .key_in        (key_in),
        .vote_ready    (vote_ready),
        .vote_valid    (vote_valid),
        .vote_idx      (vote_idx),
        .multi_err     (multi_err),
`ifdef MULTI_ERR_CNT_EN
        .multi_err_cnt (multi_err_cnt),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_multi = 0;
    int n_votes = 0;
    int mon_exp = 0;
    int sb_q[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (multi_err) begin
                n_multi++;
                $display("[TB] multi_err pulse #%0d", n_multi);
            end
            if (vote_valid && vote_ready) begin
                n_votes++;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_vote", int'(vote_idx), -1);
                end else begin
                    mon_exp = sb_q.pop_front();
                    $display("[TB] vote transfer idx=%0d expected=%0d", vote_idx, mon_exp);
                    check_eq("vote_idx", int'(vote_idx), mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_ballot();
        ballot_en = 1'b1;
        repeat (4) tick();
    endtask

    task automatic close_ballot(input string tag);
        key_in    = '0;
        ballot_en = 1'b0;
        repeat (5) tick();
        check_eq(tag, int'(busy), 0);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!vote_valid && k < 40) begin
            tick();
            k++;
        end
        check_eq(tag, int'(vote_valid), 1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        tick();
        check_eq(tag, sb_q.size(), 0);
    endtask

    int m0;
    int v0;
    logic [N_CAND-1:0] multi_pats [3] = '{16'h0003, 16'h0300, 16'hF000};

    initial begin
        // Reset state
        repeat (3) tick();
        check_eq("rst_valid", int'(vote_valid), 0);
        check_eq("rst_idx",   int'(vote_idx),   0);
        check_eq("rst_merr",  int'(multi_err),  0);
        check_eq("rst_busy",  int'(busy),       0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: latency and single transfer of candidate 5
        open_ballot();
        check_eq("t1_armed_busy", int'(busy), 1);
        sb_q.push_back(5);
        key_in = 16'h0020;
        for (int c = 1; c <= STABLE_CYCLES + 3; c++) begin
            tick();
            check_eq($sformatf("t1_lat_c%0d", c), int'(vote_valid), int'(c == STABLE_CYCLES + 3));
        end
        check_eq("t1_idx", int'(vote_idx), 5);
        tick();
        check_eq("t1_valid_drop", int'(vote_valid), 0);
        check_eq("t1_done_busy", int'(busy), 1);
        close_ballot("t1_idle");

        // 2: short bounce on key 3, then key 10 held
        open_ballot();
        m0 = n_multi;
        v0 = n_votes;
        key_in = 16'h0008;
        repeat (3) tick();
        key_in = 16'h0000;
        tick();
        sb_q.push_back(10);
        key_in = 16'h0400;
        drain("t2_drain");
        check_eq("t2_one_vote", n_votes - v0, 1);
        check_eq("t2_no_merr", n_multi - m0, 0);
        close_ballot("t2_idle");

        // 3: multi-key press, then key 0
        open_ballot();
        m0 = n_multi;
        key_in = 16'h0081;
        repeat (10) tick();
        check_eq("t3_merr_once", n_multi - m0, 1);
        check_eq("t3_no_valid", int'(vote_valid), 0);
        key_in = 16'h0000;
        repeat (4) tick();
        check_eq("t3_rearmed_busy", int'(busy), 1);
        sb_q.push_back(0);
        key_in = 16'h0001;
        drain("t3_drain");
        close_ballot("t3_idle");

        // 4: back-pressure in HOLD, committed vote, no second vote
        open_ballot();
        vote_ready = 1'b0;
        v0 = n_votes;
        sb_q.push_back(7);
        key_in = 16'h0080;
        wait_valid("t4_wait_valid");
        for (int i = 0; i < 10; i++) begin
            key_in    = 16'($urandom);
            ballot_en = (i < 5);
            tick();
            check_eq($sformatf("t4_hold_valid_%0d", i), int'(vote_valid), 1);
            check_eq($sformatf("t4_hold_idx_%0d", i), int'(vote_idx), 7);
        end
        ballot_en  = 1'b1;
        key_in     = 16'h0080;
        vote_ready = 1'b1;
        drain("t4_drain");
        repeat (12) tick();
        check_eq("t4_no_second_valid", int'(vote_valid), 0);
        check_eq("t4_one_vote", n_votes - v0, 1);
        close_ballot("t4_idle");

        // 5: key held when ballot opens
        key_in = 16'h8000;
        repeat (3) tick();
        ballot_en = 1'b1;
        repeat (10) tick();
        check_eq("t5_stays_idle", int'(busy), 0);
        key_in = 16'h0000;
        repeat (4) tick();
        check_eq("t5_armed_busy", int'(busy), 1);
        sb_q.push_back(15);
        key_in = 16'h8000;
        drain("t5_drain");
        close_ballot("t5_idle");

        // 6a: reset mid-SETTLE
        open_ballot();
        key_in = 16'h0004;
        repeat (5) tick();
        check_eq("t6_settle_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_eq("t6a_busy",  int'(busy),       0);
        check_eq("t6a_valid", int'(vote_valid), 0);
        check_eq("t6a_idx",   int'(vote_idx),   0);
        key_in = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // 6b: reset mid-HOLD drops the vote
        vote_ready = 1'b0;
        key_in = 16'h0002;
        wait_valid("t6b_wait_valid");
        rst_n = 1'b0;
        #1;
        check_eq("t6b_valid", int'(vote_valid), 0);
        check_eq("t6b_idx",   int'(vote_idx),   0);
        check_eq("t6b_busy",  int'(busy),       0);
        check_eq("t6b_merr",  int'(multi_err),  0);
`ifdef MULTI_ERR_CNT_EN
        check_eq("t6b_cnt_rst", int'(multi_err_cnt), 0);
`endif
        key_in = '0;
        repeat (2) tick();
        rst_n      = 1'b1;
        vote_ready = 1'b1;
        repeat (4) tick();

        // 6c: three multi-key events after reset
        m0 = n_multi;
        for (int p = 0; p < 3; p++) begin
            key_in = multi_pats[p];
            repeat (4) tick();
            key_in = '0;
            repeat (4) tick();
        end
        check_eq("t6c_merr_events", n_multi - m0, 3);
`ifdef MULTI_ERR_CNT_EN
        check_eq("t6c_cnt", int'(multi_err_cnt), 3);
`endif
        close_ballot("t6_idle");
        check_eq("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
